// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined ripple adder/subtractor.
// Slice width derivation and parameter legality.
package adder_pkg;

  function automatic int chunk_of(int width, int stages);
    return width / stages;
  endfunction

  function automatic bit legal_cfg(int width, int stages);
    return (stages >= 1) && (width >= 2) &&
           (width % stages == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple-carry slice.
// c_msb is the carry into the slice MSB (overflow detection).
module adder_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  always_comb begin
    logic c;
    c     = cin;
    c_msb = cin;
    s     = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined ripple adder/subtractor, one CHUNK slice per stage.
// Global stall: every stage advances together or holds.
module adder_pipe_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z
);

  localparam int CHUNK = chunk_of(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  if (!legal_cfg(WIDTH, STAGES)) begin : g_bad_cfg
    $error("adder_pipe_nbit: illegal WIDTH/STAGES");
  end

  // x_q holds finished low sum bits below pending upper A bits
  logic             v_q [STAGES];
  logic [WIDTH-1:0] x_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic             c_q [STAGES];
  logic             ov_q;
  logic             z_q;

  logic [WIDTH-1:0] px [STAGES];
  logic [WIDTH-1:0] pb [STAGES];
  logic             pc [STAGES];
  logic [WIDTH-1:0] nx [STAGES];
  logic [CHUNK-1:0] ss [STAGES];
  logic             sc [STAGES];
  logic             sm [STAGES];

  logic advance;

  assign advance   = !Out_valid | Out_ready;
  assign In_ready  = advance;
  assign Out_valid = v_q[LAST];
  assign S         = x_q[LAST];
  assign Cout      = c_q[LAST];
  assign V         = ov_q;
  assign Z         = z_q;

  always_comb begin
    px[0] = A;
    pb[0] = B ^ {WIDTH{Sub}};
    pc[0] = Cin ^ Sub;
    for (int k = 1; k < STAGES; k++) begin
      px[k] = x_q[k-1];
      pb[k] = b_q[k-1];
      pc[k] = c_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .a     (px[k][k*CHUNK +: CHUNK]),
      .b     (pb[k][k*CHUNK +: CHUNK]),
      .cin   (pc[k]),
      .s     (ss[k]),
      .cout  (sc[k]),
      .c_msb (sm[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nx[k] = px[k];
      nx[k][k*CHUNK +: CHUNK] = ss[k];
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        x_q[k] <= '0;
        b_q[k] <= '0;
        c_q[k] <= 1'b0;
      end
      ov_q <= 1'b0;
      z_q  <= 1'b0;
    end else if (advance) begin
      v_q[0] <= In_valid;
      for (int k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        x_q[k] <= nx[k];
        b_q[k] <= pb[k];
        c_q[k] <= sc[k];
      end
      ov_q <= sm[LAST] ^ sc[LAST];
      z_q  <= (nx[LAST] == '0);
    end
  end

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Bench for adder_pipe_nbit: directed table, stall/reset sequences,
// random traffic on 8-bit single- and eight-stage variants.
module tb_adder_pipe_nbit;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    res_t        r;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        In_valid;
  logic        Out_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        Sub;

  logic        In_ready, Out_valid, Cout, V, Z;
  logic [15:0] S;
  logic        rdy1, ov1, c1, v1, z1;
  logic [7:0]  s1;
  logic        rdy8, ov8, c8, v8, z8;
  logic [7:0]  s8;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  adder_pipe_nbit #(.WIDTH(16), .STAGES(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(In_valid),
    .In_ready(In_ready), .A(A), .B(B), .Cin(Cin),
    .Sub(Sub), .Out_valid(Out_valid),
    .Out_ready(Out_ready), .S(S), .Cout(Cout),
    .V(V), .Z(Z)
  );

  adder_pipe_nbit #(.WIDTH(8), .STAGES(1)) dut1 (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(In_valid),
    .In_ready(rdy1), .A(A[7:0]), .B(B[7:0]),
    .Cin(Cin), .Sub(Sub), .Out_valid(ov1),
    .Out_ready(Out_ready), .S(s1), .Cout(c1),
    .V(v1), .Z(z1)
  );

  adder_pipe_nbit #(.WIDTH(8), .STAGES(8)) dut8 (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(In_valid),
    .In_ready(rdy8), .A(A[7:0]), .B(B[7:0]),
    .Cin(Cin), .Sub(Sub), .Out_valid(ov8),
    .Out_ready(Out_ready), .S(s8), .Cout(c8),
    .V(v8), .Z(z8)
  );

  function automatic res_t model(int w, logic [15:0] a,
                                 logic [15:0] b,
                                 logic cin, logic sub);
    res_t   r;
    longint m, ua, ub, sa, sb, full, ex;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!sub) begin
      full = ua + ub + longint'(cin);
      r.c  = (full >= m);
      ex   = sa + sb + longint'(cin);
    end else begin
      full = ua - ub - longint'(cin);
      r.c  = (ua >= ub + longint'(cin));
      ex   = sa - sb - longint'(cin);
    end
    full = ((full % m) + m) % m;
    r.s  = 16'(full);
    r.v  = (ex < -(m / 2)) || (ex >= m / 2);
    r.z  = (full == 0);
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  function automatic res_t out16();
    res_t r;
    r.s = S; r.c = Cout; r.v = V; r.z = Z;
    return r;
  endfunction

  task automatic run_one(string nm, vec_t t);
    int lat;
    @(negedge Clk);
    A = t.a; B = t.b; Cin = t.cin; Sub = t.sub;
    In_valid = 1'b1; Out_ready = 1'b1;
    @(posedge Clk);
    #1 In_valid = 1'b0;
    lat = 1;
    while (!Out_valid && lat < 20) begin
      @(posedge Clk);
      #1 lat++;
    end
    chk({nm, "_lat"}, 32'(lat), 32'(4));
    chk(nm, 32'(out16()), 32'(t.r));
  endtask

  vec_t        tbl [8];
  logic [15:0] oa [8];
  logic [15:0] ob [8];
  logic        oc [8];
  logic        os [8];
  res_t        q [$];
  logic        hv [300];
  res_t        hr [300];
  int          sent, got;
  logic        hold_prev;
  logic [19:0] prev_out;
  res_t        e;

  initial begin
    tbl[0] = '{16'h1234, 16'h4321, 0, 0, '{16'h5555, 0, 0, 0}};
    tbl[1] = '{16'hFFFF, 16'h0001, 0, 0, '{16'h0000, 1, 0, 1}};
    tbl[2] = '{16'h7FFF, 16'h0001, 0, 0, '{16'h8000, 0, 1, 0}};
    tbl[3] = '{16'h0005, 16'h0007, 0, 1, '{16'hFFFE, 0, 0, 0}};
    tbl[4] = '{16'h0007, 16'h0005, 1, 1, '{16'h0001, 1, 0, 0}};
    tbl[5] = '{16'h8000, 16'h8000, 0, 0, '{16'h0000, 1, 1, 1}};
    tbl[6] = '{16'h8000, 16'h0001, 0, 1, '{16'h7FFF, 1, 1, 0}};
    tbl[7] = '{16'h1234, 16'h1234, 0, 1, '{16'h0000, 1, 0, 1}};

    Rst_n = 1'b0; In_valid = 1'b0; Out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    #12;
    chk("rst_out", 32'({Out_valid, out16()}), 32'(0));
    @(negedge Clk) Rst_n = 1'b1;
    #1 chk("rst_rdy", 32'(In_ready), 32'(1));

    for (int i = 0; i < 8; i++)
      run_one($sformatf("vec%0d", i), tbl[i]);

    // back-to-back stream with a 3-cycle consumer stall
    for (int i = 0; i < 8; i++) begin
      oa[i] = 16'($urandom); ob[i] = 16'($urandom);
      oc[i] = 1'($urandom); os[i] = 1'($urandom);
    end
    @(negedge Clk);
    sent = 0; got = 0; hold_prev = 1'b0; q.delete();
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge Clk);
      Out_ready = !(cyc >= 5 && cyc < 8);
      In_valid  = (sent < 8);
      if (sent < 8) begin
        A = oa[sent]; B = ob[sent];
        Cin = oc[sent]; Sub = os[sent];
      end
      #1;
      if (hold_prev)
        chk("hold", 32'({Out_valid, out16()}), 32'(prev_out));
      chk("stall_rdy", 32'(In_ready), 32'(Out_ready));
      if (Out_valid && Out_ready) begin
        if (q.size() == 0) chk("dup", 1, 0);
        else begin
          e = q.pop_front();
          chk("order", 32'(out16()), 32'(e));
        end
        got++;
      end
      if (In_valid && In_ready) begin
        q.push_back(model(16, A, B, Cin, Sub));
        sent++;
      end
      hold_prev = Out_valid && !Out_ready;
      prev_out  = {Out_valid, out16()};
    end
    chk("stream_cnt", 32'(got), 32'(8));
    In_valid = 1'b0; Out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      #1 chk("no_extra", 32'(Out_valid), 32'(0));
    end

    // reset with three ops in flight
    Out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      In_valid = 1'b1; A = tbl[i].a; B = tbl[i].b;
      Cin = tbl[i].cin; Sub = tbl[i].sub;
    end
    @(negedge Clk) In_valid = 1'b0;
    @(negedge Clk);
    #1 chk("pre_rst_v", 32'(Out_valid), 32'(1));
    Rst_n = 1'b0;
    #1 chk("mid_rst", 32'({Out_valid, out16()}), 32'(0));
    @(negedge Clk);
    Rst_n = 1'b1; Out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      #1 chk("post_rst", 32'(Out_valid), 32'(0));
    end
    run_one("after_rst", tbl[6]);

    // random traffic against the 8-bit variants
    @(negedge Clk);
    Rst_n = 1'b0; In_valid = 1'b0;
    @(negedge Clk) Rst_n = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge Clk);
      Out_ready = 1'b1;
      In_valid  = ($urandom % 4) != 0;
      A = 16'($urandom); B = 16'($urandom);
      Cin = 1'($urandom); Sub = 1'($urandom);
      hv[t] = In_valid;
      hr[t] = model(8, A, B, Cin, Sub);
      #1;
      chk("rdy8", 32'({rdy1, rdy8}), 32'(3));
      chk("v_s1", 32'(ov1), 32'(t >= 1 ? hv[t-1] : 1'b0));
      if (t >= 1 && hv[t-1])
        chk("r_s1", 32'({8'h00, s1, c1, v1, z1}),
            32'(hr[t-1]));
      chk("v_s8", 32'(ov8), 32'(t >= 8 ? hv[t-8] : 1'b0));
      if (t >= 8 && hv[t-8])
        chk("r_s8", 32'({8'h00, s8, c8, v8, z8}),
            32'(hr[t-8]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
